mm_addr_decoder_n: RTL

//  Parametrised MM register-bus decoder: registers one host request, routes it to one of NUM_CH

---
 rtl/mm_dec_pkg.sv | 23 ++
 rtl/mm_dec_timeout_cnt.sv | 26 ++
 rtl/mm_addr_decoder_n.sv | 163 ++++++++++++++++
 3 files changed

// File: rtl/mm_dec_pkg.sv
// Shared types and constants for the MM register-bus decoder.
package mm_dec_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } dec_state_e;

  localparam logic [31:0] UNMAPPED_TAG = 32'h5555_AAAA;
  localparam logic [31:0] TIMEOUT_TAG  = 32'hDEAD_BEEF;

  // Tag in the top 32 bits of a data_w-wide word, address right-justified, zeros between.
  // The caller truncates the 256-bit result to its own data width.
  function automatic logic [255:0] build_err_data(input logic [31:0]  tag,
                                                  input logic [255:0] addr,
                                                  input int           data_w);
    logic [255:0] t;
    t = 256'(tag);
    return (t << (data_w - 32)) | addr;
  endfunction

endpackage

// File: rtl/mm_dec_timeout_cnt.sv
// Read-wait cycle counter: restarts at 0 whenever run drops, flags expiry at TIMEOUT_CYC.
module mm_dec_timeout_cnt
  #(parameter int TIMEOUT_CYC = 255)
  (
    input  logic clk,
    input  logic rst,
    input  logic run,
    output logic expire
  );

  localparam int CLOG  = $clog2(TIMEOUT_CYC + 1);
  localparam int CNT_W = (CLOG > 8) ? CLOG : 8;

  logic [CNT_W-1:0] cnt_q;

  assign expire = run && (cnt_q == CNT_W'(TIMEOUT_CYC));

  always_ff @(posedge clk) begin
    if (rst || !run) begin
      cnt_q <= '0;
    end else if (!expire) begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

endmodule

// File: rtl/mm_addr_decoder_n.sv
// MM register-bus decoder: one registered host request routed to NUM_CH channel slaves.
// Optional read timeout enabled by defining MM_DEC_TIMEOUT_EN.
module mm_addr_decoder_n
  import mm_dec_pkg::*;
  #(
    parameter int NUM_CH      = 4,
    parameter int ADDR_W      = 17,
    parameter int DATA_W      = 64,
    parameter int SEL_W       = 3,
    parameter int TIMEOUT_CYC = 255
  )
  (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     iMM_WR_EN,
    input  logic                     iMM_RD_EN,
    input  logic [ADDR_W-1:0]        iMM_ADDR,
    input  logic [DATA_W-1:0]        iMM_WR_DATA,
    output logic [DATA_W-1:0]        oMM_RD_DATA,
    output logic                     oMM_RD_DATA_V,
    output logic                     oMM_RD_ERR,
    output logic                     oMM_BUSY,
    output logic [15:0]              oMM_OVR_CNT,
    output logic [ADDR_W-1:0]        oCH_ADDR,
    output logic [DATA_W-1:0]        oCH_WR_DATA,
    output logic [NUM_CH-1:0]        oCH_WR_EN,
    output logic [NUM_CH-1:0]        oCH_RD_EN,
    input  logic [NUM_CH*DATA_W-1:0] iCH_RD_DATA,
    input  logic [NUM_CH-1:0]        iCH_RD_DATA_V
  );

  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  logic [ADDR_W-1:0] addr_p1;
  logic [DATA_W-1:0] wdata_p1;
  logic              wr_vld_p1;
  logic              rd_vld_p1;
  logic [SEL_W-1:0]  sel_p1;
  logic              mapped_p1;
  logic              rd_accept;
  logic              rd_drop;

  dec_state_e        state_q;
  dec_state_e        state_d;
  logic [SEL_W-1:0]  rd_sel_p2;
  logic [ADDR_W-1:0] rd_addr_p2;
  logic              unm_p2;
  logic              sl_vld;
  logic [DATA_W-1:0] sl_data;
  logic              expire;

  logic [DATA_W-1:0] rd_data_q;
  logic              rd_v_q;
  logic              rd_err_q;
  logic [15:0]       ovr_cnt_q;

  // Stage 1: register the host request
  always_ff @(posedge clk) begin
    if (rst) begin
      addr_p1   <= '0;
      wdata_p1  <= '0;
      wr_vld_p1 <= 1'b0;
      rd_vld_p1 <= 1'b0;
    end else begin
      addr_p1   <= iMM_ADDR;
      wdata_p1  <= iMM_WR_DATA;
      wr_vld_p1 <= iMM_WR_EN;
      rd_vld_p1 <= iMM_RD_EN;
    end
  end

  assign sel_p1    = addr_p1[ADDR_W-1 -: SEL_W];
  assign mapped_p1 = 32'(sel_p1) < 32'(NUM_CH);
  assign rd_accept = rd_vld_p1 && (state_q == IDLE);
  assign rd_drop   = rd_vld_p1 && (state_q != IDLE);

  // Strobe fan-out for the registered request; read-data mux for the latched channel
  always_comb begin
    oCH_WR_EN = '0;
    oCH_RD_EN = '0;
    sl_vld    = 1'b0;
    sl_data   = '0;
    for (int k = 0; k < NUM_CH; k++) begin
      if (sel_p1 == SEL_W'(k)) begin
        oCH_WR_EN[k] = wr_vld_p1;
        oCH_RD_EN[k] = rd_accept;
      end
      if (rd_sel_p2 == SEL_W'(k)) begin
        sl_vld  = iCH_RD_DATA_V[k];
        sl_data = iCH_RD_DATA[k*DATA_W +: DATA_W];
      end
    end
  end

`ifdef MM_DEC_TIMEOUT_EN
  mm_dec_timeout_cnt #(.TIMEOUT_CYC(TIMEOUT_CYC)) u_timeout (
    .clk    (clk),
    .rst    (rst),
    .run    (state_q == WAIT),
    .expire (expire)
  );
`else
  assign expire = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (rd_accept) state_d = mapped_p1 ? WAIT : RESP;
      WAIT:    if (sl_vld || expire) state_d = RESP;
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Stage 2: read tracking and response
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      rd_sel_p2  <= '0;
      rd_addr_p2 <= '0;
      unm_p2     <= 1'b0;
      rd_data_q  <= '0;
      rd_v_q     <= 1'b0;
      rd_err_q   <= 1'b0;
      ovr_cnt_q  <= '0;
    end else begin
      state_q  <= state_d;
      rd_v_q   <= 1'b0;
      rd_err_q <= 1'b0;
      if (rd_drop) ovr_cnt_q <= sat_inc16(ovr_cnt_q);
      if (rd_accept) begin
        rd_sel_p2  <= sel_p1;
        rd_addr_p2 <= addr_p1;
        unm_p2     <= !mapped_p1;
      end
      // Slave data has priority over a timeout expiring in the same cycle
      if (state_q == WAIT && sl_vld) begin
        rd_data_q <= sl_data;
        rd_v_q    <= 1'b1;
      end else if (state_q == WAIT && expire) begin
        rd_data_q <= DATA_W'(build_err_data(TIMEOUT_TAG, 256'(rd_addr_p2), DATA_W));
        rd_v_q    <= 1'b1;
        rd_err_q  <= 1'b1;
      end else if (state_q == RESP && unm_p2) begin
        rd_data_q <= DATA_W'(build_err_data(UNMAPPED_TAG, 256'(rd_addr_p2), DATA_W));
        rd_v_q    <= 1'b1;
        rd_err_q  <= 1'b1;
      end
    end
  end

  assign oMM_RD_DATA   = rd_data_q;
  assign oMM_RD_DATA_V = rd_v_q;
  assign oMM_RD_ERR    = rd_err_q;
  assign oMM_BUSY      = (state_q != IDLE) || rd_vld_p1;
  assign oMM_OVR_CNT   = ovr_cnt_q;
  assign oCH_ADDR      = addr_p1;
  assign oCH_WR_DATA   = wdata_p1;

endmodule
